// File: rtl/apb_pkg.sv
// ============================================================================
// Module      : apb_pkg
// Description : Shared register-map addresses and master FSM state encoding
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_pkg;

  localparam int unsigned ADDR_REGA = 5;
  localparam int unsigned ADDR_REGB = 10;
  localparam int unsigned ADDR_REGC = 15;
  localparam int unsigned ADDR_REGD = 20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SETUP  = 2'd2,
    ACCESS = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/apb_slave_regs.sv
// ============================================================================
// Module      : apb_slave_regs
// Description : Zero-wait-state APB3 slave with four registers and error decode
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_slave_regs
  import apb_pkg::*;
#(
  parameter int               ADDR_W     = 32,
  parameter int               DATA_W     = 32,
  parameter logic [DATA_W-1:0] REGD_VALUE = DATA_W'(32'h0000_00AA)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam logic [ADDR_W-1:0] c_addr_a = ADDR_W'(ADDR_REGA);
  localparam logic [ADDR_W-1:0] c_addr_b = ADDR_W'(ADDR_REGB);
  localparam logic [ADDR_W-1:0] c_addr_c = ADDR_W'(ADDR_REGC);
  localparam logic [ADDR_W-1:0] c_addr_d = ADDR_W'(ADDR_REGD);

  logic [DATA_W-1:0] r_reg_a;
  logic [DATA_W-1:0] r_reg_b;
  logic [DATA_W-1:0] r_reg_c;
  logic              w_access;
  logic              w_err;

  assign w_access = psel & penable;
  assign pready   = w_access;

  // regC is write-only and regD read-only; anything off-map also errors
  always_comb begin
    w_err = 1'b1;
    if (paddr == c_addr_a || paddr == c_addr_b) w_err = 1'b0;
    else if (paddr == c_addr_c)                 w_err = ~pwrite;
    else if (paddr == c_addr_d)                 w_err = pwrite;
  end

  assign pslverr = w_access & w_err;

  always_comb begin
    prdata = '0;
    if      (paddr == c_addr_a) prdata = r_reg_a;
    else if (paddr == c_addr_b) prdata = r_reg_b;
    else if (paddr == c_addr_d) prdata = REGD_VALUE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reg_a <= '0;
      r_reg_b <= '0;
      r_reg_c <= '0;
    end else if (w_access && pwrite && !w_err) begin
      if (paddr == c_addr_a) r_reg_a <= pwdata;
      if (paddr == c_addr_b) r_reg_b <= pwdata;
      if (paddr == c_addr_c) r_reg_c <= pwdata;
    end
  end

endmodule

`default_nettype wire

// File: rtl/apb_master_slave_top.sv
// ============================================================================
// Module      : apb_master_slave_top
// Description : APB master FSM issuing single transfers to the internal slave
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_master_slave_top
  import apb_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] REGD_VALUE = DATA_W'(32'h0000_00AA)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  input  logic              st_wr_rd,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  state_e            r_state;
  state_e            w_next;
  logic              r_dir;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              w_psel;
  logic              w_penable;
  logic [DATA_W-1:0] w_prdata;
  logic              w_pready;
  logic              w_pslverr;
  logic              w_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_psel    = 1'b0;
    w_penable = 1'b0;
    case (r_state)
      IDLE:   if (start_valid) w_next = WAIT;
      WAIT:   w_next = SETUP;
      SETUP: begin
        w_psel = 1'b1;
        w_next = ACCESS;
      end
      ACCESS: begin
        w_psel    = 1'b1;
        w_penable = 1'b1;
        if (w_pready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_done = (r_state == ACCESS) && w_pready;

  // Address/data are captured one cycle after the request, once the user side has settled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dir    <= 1'b0;
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
      rd_data  <= '0;
    end else begin
      if (r_state == IDLE && start_valid) r_dir <= st_wr_rd;
      if (r_state == WAIT) begin
        r_paddr  <= r_dir ? wr_addr : rd_addr;
        r_pwdata <= wr_data;
        r_pwrite <= r_dir;
      end
      if (w_done && !r_pwrite && !w_pslverr) rd_data <= w_prdata;
    end
  end

  apb_slave_regs #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .REGD_VALUE (REGD_VALUE)
  ) u_slave (
    .clk     (clk),
    .rst     (rst),
    .psel    (w_psel),
    .penable (w_penable),
    .pwrite  (r_pwrite),
    .paddr   (r_paddr),
    .pwdata  (r_pwdata),
    .prdata  (w_prdata),
    .pready  (w_pready),
    .pslverr (w_pslverr)
  );

endmodule

`default_nettype wire

// File: tb/tb_apb_master_slave_top.sv
// ============================================================================
// Module      : tb_apb_master_slave_top
// Description : Directed, scoreboard-based bench for apb_master_slave_top
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_master_slave_top;
  import apb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        st_wr_rd;
  logic [31:0] wr_data;
  logic [31:0] wr_addr;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_a, m_b, m_c, m_rd;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  apb_master_slave_top dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .st_wr_rd    (st_wr_rd),
    .wr_data     (wr_data),
    .wr_addr     (wr_addr),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic dir, input logic [31:0] addr);
    if (addr == 5 || addr == 10) return 1'b0;
    if (addr == 15) return ~dir;
    if (addr == 20) return dir;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] addr);
    case (addr)
      32'd5:   return m_a;
      32'd10:  return m_b;
      32'd20:  return 32'h0000_00AA;
      default: return 32'h0;
    endcase
  endfunction

  // One transfer; poke=1 pulses start_valid during ACCESS to confirm it is ignored
  task automatic xfer(input string tag, input logic dir, input logic [31:0] addr,
                      input logic [31:0] data, input bit poke);
    logic e;
    int   k;
    e = model_err(dir, addr);
    if (!e) begin
      if (dir) begin
        if (addr == 5)  m_a = data;
        if (addr == 10) m_b = data;
        if (addr == 15) m_c = data;
      end else begin
        m_rd = model_rd(addr);
      end
    end
    exp_q.push_back(m_rd);

    @(negedge clk);
    start_valid = 1'b1;
    st_wr_rd    = dir;
    wr_addr     = addr;
    rd_addr     = addr;
    wr_data     = data;
    @(posedge clk);
    #1 start_valid = 1'b0;
    k = 0;
    while (dut.r_state !== ACCESS && k < 8) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'd3);
    check({tag, "_pslverr"}, {31'b0, dut.w_pslverr}, {31'b0, e});
    check({tag, "_psel_pen"}, {30'b0, dut.w_psel, dut.w_penable}, 32'd3);
    if (poke) start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    check({tag, "_rd_data"}, rd_data, exp_q.pop_front());
    check({tag, "_idle"}, 32'(dut.r_state), 32'(IDLE));
    if (poke) begin
      repeat (2) @(negedge clk);
      check({tag, "_poke_ignored"}, 32'(dut.r_state), 32'(IDLE));
    end
  endtask

  initial begin
    rst = 1'b0;
    start_valid = 1'b0;
    st_wr_rd = 1'b0;
    wr_data = '0;
    wr_addr = '0;
    rd_addr = '0;
    m_a = '0; m_b = '0; m_c = '0; m_rd = '0;

    repeat (2) @(negedge clk);
    check("rst_state", 32'(dut.r_state), 32'(IDLE));
    check("rst_psel", {30'b0, dut.w_psel, dut.w_penable}, 32'd0);
    check("rst_paddr", dut.r_paddr, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    rst = 1'b1;

    xfer("t1_wr_a", 1'b1, 32'd5, 32'd99, 1'b0);
    xfer("t1_rd_a", 1'b0, 32'd5, 32'd0, 1'b0);
    xfer("t2_wr_b", 1'b1, 32'd10, 32'd52, 1'b0);
    xfer("t2_rd_b", 1'b0, 32'd10, 32'd0, 1'b0);
    xfer("t2_rd_a", 1'b0, 32'd5, 32'd0, 1'b0);
    xfer("t3_wr_c0", 1'b1, 32'd15, 32'd54, 1'b0);
    xfer("t3_wr_c1", 1'b1, 32'd15, 32'd53, 1'b0);
    xfer("t3_wr_c2", 1'b1, 32'd15, 32'd52, 1'b0);
    check("t3_reg_c", dut.u_slave.r_reg_c, m_c);
    for (int i = 0; i < 3; i++) xfer("t4_rd_d", 1'b0, 32'd20, 32'd0, 1'b0);
    xfer("t5_rd_c", 1'b0, 32'd15, 32'd0, 1'b0);
    xfer("t5_wr_d", 1'b1, 32'd20, 32'd45, 1'b0);
    xfer("t5_rd_d", 1'b0, 32'd20, 32'd0, 1'b0);
    xfer("t5_wr_unmapped", 1'b1, 32'd7, 32'd1234, 1'b0);
    check("t5_reg_a", dut.u_slave.r_reg_a, m_a);
    check("t5_reg_b", dut.u_slave.r_reg_b, m_b);
    xfer("t5_rd_unmapped", 1'b0, 32'd21, 32'd0, 1'b0);
    xfer("t6_wr_a_poke", 1'b1, 32'd5, 32'd17, 1'b1);
    xfer("t6_rd_a", 1'b0, 32'd5, 32'd0, 1'b0);

    // Reset in the middle of SETUP must abort the write outright
    @(negedge clk);
    start_valid = 1'b1;
    st_wr_rd    = 1'b1;
    wr_addr     = 32'd10;
    wr_data     = 32'd77;
    @(posedge clk);
    #1 start_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_in_setup", 32'(dut.r_state), 32'(SETUP));
    rst = 1'b0;
    #1;
    check("t6_rst_state", 32'(dut.r_state), 32'(IDLE));
    check("t6_rst_reg_a", dut.u_slave.r_reg_a, 32'd0);
    check("t6_rst_reg_b", dut.u_slave.r_reg_b, 32'd0);
    check("t6_rst_reg_c", dut.u_slave.r_reg_c, 32'd0);
    check("t6_rst_rd_data", rd_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    m_a = '0; m_b = '0; m_c = '0; m_rd = '0;
    xfer("t6_post_rd_b", 1'b0, 32'd10, 32'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
